lsu_obi_pipelined: RTL and testbench
====================================

Name: lsu_obi_pipelined

Overview:
- Parametrised load/store unit for the riscv32i core, sitting between EXEC/MEM and the OBI-style data port (req/gnt/rvalid).
- Successor to the single-request data-memory FSM. It keeps up to MAX_OUTSTANDING transactions in flight, returns responses in order with a tag, generates byte enables for loads too, and detects misaligned accesses locally.

Parameters:
- MAX_OUTSTANDING, 2, depth of the pending-transaction queue; power of 2, ≥1.
- TAG_W, 5, width of the request tag (rd index).
- PERIPH_START, 32'h00002600, inclusive lower bound of the peripheral window.
- PERIPH_END, 32'h00002800, exclusive upper bound of the peripheral window.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  1  EXEC presents a load/store.
- req_ready_o  out  1  request accepted this cycle.
- req_we_i  in  1  1=store, 0=load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
- req_unsigned_i  in  1  zero-extend load (LBU/LHU).
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, LSB-aligned.
- req_tag_i  in  TAG_W  returned with the response.
- rsp_valid_o  out  1  response valid (single cycle).
- rsp_we_o  out  1  response belongs to a store.
- rsp_err_o  out  1  misaligned / reserved-size error.
- rsp_tag_o  out  TAG_W  tag of the responding request.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- busy_o  out  1  pending count ≠ 0 or error response pending.
- in_range_peripheral_o  out  1  PERIPH_START ≤ req_addr_i < PERIPH_END (combinational).
- final_value_o  out  32  debug shadow of the word at PERIPH_START.
- data_req_o  out  1  memory request.
- data_addr_o  out  32  word-aligned address ({req_addr_i[31:2],2'b00}).
- data_we_o  out  1  memory write.
- data_be_o  out  4  byte enables.
- data_wdata_o  out  32  lane-shifted store data.
- data_gnt_i  in  1  memory grant.
- data_rvalid_i  in  1  memory response valid.
- data_rdata_i  in  32  memory read data.

Behaviour:
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0, or size 11.
- Byte enables:
  - byte: 4'b0001<<off.
  - half: off 0→0011, off 2→1100.
  - word: 1111.
  - data_wdata_o = wdata replicated and shifted into the enabled lanes.
- Aligned request path:
  - data_req_o = req_valid_i & aligned & (count < MAX_OUTSTANDING), combinational.
  - addr/we/be/wdata are valid only while data_req_o=1; they are 0 otherwise.
  - Handshake: data_req_o & data_gnt_i. That cycle req_ready_o=1 and {we, size, unsigned, off, tag} is pushed to the pending queue.
- Misaligned path:
  - Accepted only when count==0 and no error pending; data_req_o=0.
  - req_ready_o=1 that cycle.
  - Next cycle: rsp_valid_o=1, rsp_err_o=1, tag echoed, rdata 0.
- Response path:
  - When data_rvalid_i & count≠0: pop the queue, and in the same cycle drive rsp_valid_o=1 with the popped tag/we.
  - rsp_rdata_o is extracted from data_rdata_i using the popped off/size/unsigned (sign-extend unless unsigned).
  - data_rvalid_i with count==0 is ignored.
- Pending count:
  - A simultaneous push and pop leaves the count unchanged.
  - Memory guarantees rvalid ≥1 cycle after its gnt, so push and pop never target the same entry in one cycle.
- Full condition: count==MAX_OUTSTANDING → data_req_o=0 and req_ready_o=0, even if rvalid arrives that cycle (no same-cycle bypass).
- Reset:
  - Queue and count cleared; the error-pending register is cleared.
  - All outputs are 0; in_range_peripheral_o stays combinational.
  - rvalids arriving after reset for pre-reset requests are dropped (count==0).
  - A request held across deassertion of reset is handled normally.

Optional Feature:
- Macro LSU_FINAL_VALUE_EN.
- Defined: a 32-bit register is reset to 0. On each granted store whose word address equals PERIPH_START[31:2], it updates the enabled bytes from data_wdata_o. final_value_o drives this register.
- Undefined: final_value_o is tied to 0 and no register is built.

Decomposition:
- Package lsu_pkg holds:
  - size encodings (SZ_B, SZ_H, SZ_W);
  - the pending-entry struct {we, size, uns, off[1:0], tag} with its width constant;
  - the byte-enable lookup function.
- Sub-module lsu_pending_fifo: synchronous FIFO of entries, DEPTH=MAX_OUTSTANDING.
  - Ports: push, pop, wdata, rdata (head, combinational), count, full, empty.
  - Pointers wrap modulo DEPTH.

Test Plan:
1. LW 0x2804, tag 7; gnt same cycle; rvalid next cycle with rdata 0xDEADBEEF → rsp_valid_o=1, tag 7, rsp_rdata_o=0xDEADBEEF, data_be_o=1111.
2. LB at 0x2803 with rdata 0x80FF0000 → rsp_rdata_o=0xFFFFFF80 and be=1000. The same access as LBU → 0x00000080.
3. MAX_OUTSTANDING=2: LW tags 5 and 6 granted back-to-back with rvalids delayed 3 cycles.
   - A third request sees data_req_o=0 until the first rvalid.
   - Responses arrive in order, tags 5 then 6.
4. SH 0x2602 with wdata 0x00001234 → be=1100, data_wdata_o=0x12341234 (lanes 3:2 carry 0x1234). With LSU_FINAL_VALUE_EN, final_value_o=0x12340000 next cycle.
5. LW 0x2801, tag 3, queue empty → data_req_o stays 0, req_ready_o=1. Next cycle rsp_valid_o=1, rsp_err_o=1, tag 3, rdata 0.
6. Two loads outstanding, then assert reset for 1 cycle, then send their rvalids → rsp_valid_o stays 0, busy_o=0, count=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the pipelined load/store unit.
// Holds size encodings, the pending-transaction entry layout and the
// byte-enable / alignment helpers used by the request and response paths.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Tag field is sized for the widest tag any instance may use; the top
  // zero-extends its TAG_W-bit tag into it (TAG_W must not exceed this).
  localparam int unsigned TAG_MAX_W = 16;

  typedef struct packed {
    logic                 we;
    logic [1:0]           size;
    logic                 uns;
    logic [1:0]           off;
    logic [TAG_MAX_W-1:0] tag;
  } pend_t;

  localparam int unsigned PEND_W = $bits(pend_t);

  function automatic logic [3:0] be_lookup(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    be_lookup = 4'b0001 << off;
      SZ_H:    be_lookup = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be_lookup = 4'b1111;
      default: be_lookup = 4'b0000;
    endcase
  endfunction

  // Reserved size 11 is reported as misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_pending_fifo.sv
// Synchronous FIFO of pending-transaction entries; head is read combinationally.
// Ports: clk, reset (sync, active-high), push/wdata, pop, rdata (head),
//        count, full, empty. Pointers wrap modulo DEPTH (any DEPTH >= 1).
module lsu_pending_fifo
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = PEND_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    ptr_next = (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/lsu_obi_pipelined.sv
// Pipelined load/store unit between EXEC/MEM and an OBI data port (req/gnt/rvalid).
// Ports: req_* from EXEC (valid/ready), rsp_* in-order tagged responses, data_* OBI
//        master, busy/in_range/final_value status. Optional macro LSU_FINAL_VALUE_EN
//        builds a shadow of the word at PERIPH_START on final_value_o.
module lsu_obi_pipelined
  import lsu_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TAG_W           = 5,
  parameter logic [31:0] PERIPH_START    = 32'h0000_2600,
  parameter logic [31:0] PERIPH_END      = 32'h0000_2800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_unsigned_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  output logic             rsp_we_o,
  output logic             rsp_err_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [31:0]      rsp_rdata_o,
  output logic             busy_o,
  output logic             in_range_peripheral_o,
  output logic [31:0]      final_value_o,
  output logic             data_req_o,
  output logic [31:0]      data_addr_o,
  output logic             data_we_o,
  output logic [3:0]       data_be_o,
  output logic [31:0]      data_wdata_o,
  input  logic             data_gnt_i,
  input  logic             data_rvalid_i,
  input  logic [31:0]      data_rdata_i
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING+1);

  logic [1:0]       off;
  logic             mis;
  logic [3:0]       be;
  logic [31:0]      wdata_lanes;
  logic             push;
  logic             pop;
  logic             mis_accept;
  logic             pend_full;
  logic             pend_empty;
  logic [CNT_W-1:0] pend_count;
  pend_t            push_ent;
  pend_t            head;
  logic             err_q;
  logic             err_we_q;
  logic [TAG_W-1:0] err_tag_q;
  logic [31:0]      lane;
  logic [31:0]      ld_data;

  assign off = req_addr_i[1:0];
  assign mis = misaligned(req_size_i, off);
  assign be  = be_lookup(req_size_i, off);

  // Replicating the low bytes across the word puts them in every lane the
  // byte enables can select.
  always_comb begin
    case (req_size_i)
      SZ_B:    wdata_lanes = {4{req_wdata_i[7:0]}};
      SZ_H:    wdata_lanes = {2{req_wdata_i[15:0]}};
      default: wdata_lanes = req_wdata_i;
    endcase
  end

  // Full blocks new requests even when an rvalid frees a slot this cycle.
  assign data_req_o   = ~reset & req_valid_i & ~mis & ~pend_full;
  assign push         = data_req_o & data_gnt_i;
  assign mis_accept   = ~reset & req_valid_i & mis & (pend_count == '0) & ~err_q;
  assign req_ready_o  = push | mis_accept;
  assign pop          = ~reset & data_rvalid_i & ~pend_empty;

  assign data_addr_o  = data_req_o ? {req_addr_i[31:2], 2'b00} : '0;
  assign data_we_o    = data_req_o & req_we_i;
  assign data_be_o    = data_req_o ? be : '0;
  assign data_wdata_o = data_req_o ? wdata_lanes : '0;

  always_comb begin
    push_ent      = '0;
    push_ent.we   = req_we_i;
    push_ent.size = req_size_i;
    push_ent.uns  = req_unsigned_i;
    push_ent.off  = off;
    push_ent.tag  = TAG_MAX_W'(req_tag_i);
  end

  lsu_pending_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (PEND_W)
  ) u_pending (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_ent),
    .rdata (head),
    .count (pend_count),
    .full  (pend_full),
    .empty (pend_empty)
  );

  // Misaligned requests never touch memory; their error response is
  // presented one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q     <= 1'b0;
      err_we_q  <= 1'b0;
      err_tag_q <= '0;
    end else begin
      err_q <= mis_accept;
      if (mis_accept) begin
        err_we_q  <= req_we_i;
        err_tag_q <= req_tag_i;
      end
    end
  end

  always_comb begin
    lane = data_rdata_i >> {head.off, 3'b000};
    case (head.size)
      SZ_B:    ld_data = head.uns ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SZ_H:    ld_data = head.uns ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  // A memory pop and an error response cannot coincide: errors are only
  // accepted with an empty queue.
  assign rsp_valid_o = pop | (~reset & err_q);
  assign rsp_err_o   = ~reset & err_q;
  assign rsp_we_o    = pop ? head.we : (~reset & err_q & err_we_q);
  assign rsp_tag_o   = pop ? TAG_W'(head.tag) : ((~reset & err_q) ? err_tag_q : '0);
  assign rsp_rdata_o = (pop & ~head.we) ? ld_data : '0;
  assign busy_o      = ~reset & (~pend_empty | err_q);

  assign in_range_peripheral_o = (req_addr_i >= PERIPH_START) && (req_addr_i < PERIPH_END);

`ifdef LSU_FINAL_VALUE_EN
  logic [31:0] final_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      final_q <= '0;
    end else if (push && req_we_i && (req_addr_i[31:2] == PERIPH_START[31:2])) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) final_q[8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  assign final_value_o = reset ? '0 : final_q;
`else
  assign final_value_o = '0;
`endif

endmodule

// File: tb/tb_lsu_obi_pipelined.sv
module tb_lsu_obi_pipelined;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid_i = 0, req_we_i = 0, req_unsigned_i = 0;
  logic [1:0]  req_size_i = 0;
  logic [31:0] req_addr_i = 0, req_wdata_i = 0;
  logic [4:0]  req_tag_i = 0;
  logic        req_ready_o, rsp_valid_o, rsp_we_o, rsp_err_o, busy_o, in_range_peripheral_o;
  logic [4:0]  rsp_tag_o;
  logic [31:0] rsp_rdata_o, final_value_o;
  logic        data_req_o, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_gnt_i = 0, data_rvalid_i = 0;
  logic [31:0] data_rdata_i = 0;

  always #5 clk = ~clk;

  lsu_obi_pipelined #(.MAX_OUTSTANDING(MAXO), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o),
    .rsp_tag_o(rsp_tag_o), .rsp_rdata_o(rsp_rdata_o), .busy_o(busy_o),
    .in_range_peripheral_o(in_range_peripheral_o), .final_value_o(final_value_o),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  typedef struct { int due; logic [31:0] rdata; } mem_t;
  typedef struct { logic we; logic err; logic [4:0] tag; logic [31:0] rdata; } exp_t;

  mem_t mq[$];   // memory-side: granted transactions awaiting rvalid
  exp_t sb[$];   // scoreboard: expected responses in order

  int checks = 0, errors = 0, cyc = 0;
  bit m_err = 0;
  logic [31:0] m_fv = 0;

  // request / environment knobs
  logic        r_v = 0, r_we = 0, r_uns = 0;
  logic [1:0]  r_sz = 0;
  logic [31:0] r_addr = 0, r_wd = 0;
  logic [4:0]  r_tag = 0;
  int gnt_mode = 1, dly_mode = 0, stray_force = 0;
  bit rd_fix = 0, last_acc = 0;
  logic [31:0] rd_val = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %08h required %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Load result from memory word: pick the addressed bytes, then sign-extend
  // by two's-complement wrap unless unsigned.
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] off, input logic [31:0] rd);
    int nb = nbytes(sz);
    logic [31:0] v = rd >> (8 * off);
    if (nb == 4) return v;
    v = v & ((32'd1 << (8 * nb)) - 32'd1);
    if (!uns && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
    return v;
  endfunction

  task automatic step();
    int inflight, nb;
    bit err_start, popped, mis, exp_req, g, push, acc_mis;
    logic [1:0] off;
    logic [3:0] ebe;
    logic [31:0] ewd, rd;
    mem_t m;
    exp_t e;
    @(posedge clk); #1;
    cyc++;
    reset = 0;
    inflight = mq.size();
    err_start = m_err;
    req_valid_i = r_v; req_we_i = r_we; req_size_i = r_sz; req_unsigned_i = r_uns;
    req_addr_i = r_addr; req_wdata_i = r_wd; req_tag_i = r_tag;
    popped = 0; data_rvalid_i = 0; data_rdata_i = $urandom; data_gnt_i = 0;
    if (inflight > 0 && mq[0].due <= cyc) begin
      data_rvalid_i = 1; data_rdata_i = mq[0].rdata; popped = 1;
    end else if (inflight == 0 && (stray_force > 0 || $urandom_range(0, 7) == 0)) begin
      data_rvalid_i = 1;
      if (stray_force > 0) stray_force--;
    end
    #1;
    off = r_addr[1:0];
    nb = nbytes(r_sz);
    mis = (r_sz == 2'b11) || ((int'(off) % nb) != 0);
    exp_req = r_v && !mis && (inflight < MAXO);
    chk("data_req", data_req_o, exp_req);
    chk("busy", busy_o, (inflight > 0) || err_start);
    chk("in_range", in_range_peripheral_o, (r_addr >= 32'h2600) && (r_addr < 32'h2800));
    chk("final_value", final_value_o, m_fv);
    ebe = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = r_wd[8*(i % nb) +: 8];
    if (exp_req) begin
      chk("data_addr", data_addr_o, {r_addr[31:2], 2'b00});
      chk("data_we", data_we_o, r_we);
      chk("data_be", data_be_o, ebe);
      chk("data_wdata", data_wdata_o, ewd);
    end else begin
      chk("idle_addr_wdata", data_addr_o | data_wdata_o, 0);
      chk("idle_be_we", {data_be_o, data_we_o}, 0);
    end
    case (gnt_mode)
      0:       g = 0;
      1:       g = 1;
      default: g = ($urandom_range(0, 2) != 0);
    endcase
    data_gnt_i = g;
    #1;
    push = exp_req && g;
    acc_mis = r_v && mis && (inflight == 0) && !err_start;
    chk("req_ready", req_ready_o, push || acc_mis);
    last_acc = push || acc_mis;
    if (popped) mq.delete(0);
    m_err = acc_mis;
    if (push) begin
      rd = rd_fix ? rd_val : $urandom;
      m.due = cyc + 1 + ((dly_mode < 0) ? int'($urandom_range(0, 4)) : dly_mode);
      m.rdata = rd;
      mq.push_back(m);
      e.we = r_we; e.err = 0; e.tag = r_tag;
      e.rdata = r_we ? 32'd0 : ref_load(r_sz, r_uns, off, rd);
      sb.push_back(e);
`ifdef LSU_FINAL_VALUE_EN
      if (r_we && (r_addr >> 2) == (32'h2600 >> 2))
        for (int i = 0; i < 4; i++) if (ebe[i]) m_fv[8*i +: 8] = ewd[8*i +: 8];
`endif
    end
    if (acc_mis) begin
      e.we = r_we; e.err = 1; e.tag = r_tag; e.rdata = 0;
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] tag);
    r_v = 1; r_we = we; r_sz = sz; r_uns = uns; r_addr = addr; r_wd = wd; r_tag = tag;
    last_acc = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (last_acc) break;
    end
    checks++;
    if (!last_acc) begin
      errors++;
      $display("FAIL send_timeout: actual not accepted required accepted (tag %0d)", tag);
    end
    r_v = 0;
  endtask

  task automatic idle(input int n);
    r_v = 0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drain();
    r_v = 0;
    for (int k = 0; k < 100 && (mq.size() > 0 || m_err || sb.size() > 0); k++) step();
    checks++;
    if (mq.size() > 0 || m_err || sb.size() > 0) begin
      errors++;
      $display("FAIL drain: actual %0d responses outstanding required 0", sb.size());
    end
  endtask

  task automatic apply_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cyc++;
      reset = 1;
      req_valid_i = 1; req_we_i = 0; req_size_i = 2'b10; req_addr_i = 32'h2604;
      data_gnt_i = 1; data_rvalid_i = 1; data_rdata_i = $urandom;
      #1;
      chk("rst_data_req", data_req_o, 0);
      chk("rst_req_ready", req_ready_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_final", final_value_o, 0);
      chk("rst_bus", data_addr_o | data_wdata_o | {27'd0, data_be_o, data_we_o}, 0);
      chk("rst_in_range", in_range_peripheral_o, 1);
    end
    mq.delete(); sb.delete(); m_err = 0; m_fv = 0;
  endtask

  // Monitor: every presented response must match the head of the scoreboard.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset && rsp_valid_o) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: actual valid with tag %0d required no response", rsp_tag_o);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_tag", rsp_tag_o, mon_e.tag);
        chk("rsp_we", rsp_we_o, mon_e.we);
        chk("rsp_err", rsp_err_o, mon_e.err);
        chk("rsp_rdata", rsp_rdata_o, mon_e.rdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running required finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] base;
    apply_reset(3);

    // 1: LW 0x2804 tag 7, rvalid next cycle
    gnt_mode = 1; dly_mode = 0; rd_fix = 1; rd_val = 32'hDEAD_BEEF;
    send(0, 2'b10, 0, 32'h2804, 0, 7);
    drain();

    // 2: LB / LBU at 0x2803
    rd_val = 32'h80FF_0000;
    send(0, 2'b00, 0, 32'h2803, 0, 1);
    send(0, 2'b00, 1, 32'h2803, 0, 2);
    drain();

    // 3: two LWs outstanding, third blocked until first rvalid
    dly_mode = 3; rd_fix = 0;
    send(0, 2'b10, 0, 32'h2800, 0, 5);
    send(0, 2'b10, 0, 32'h2804, 0, 6);
    send(0, 2'b10, 0, 32'h2808, 0, 9);
    drain();

    // 4: SH into the peripheral word
    dly_mode = 0;
    send(1, 2'b01, 0, 32'h2602, 32'h0000_1234, 1);
    idle(2);
    drain();

    // 5: misaligned LW with empty queue
    send(0, 2'b10, 0, 32'h2801, 0, 3);
    drain();

    // 6: reset with two loads outstanding; stale rvalids follow
    dly_mode = 20;
    send(0, 2'b10, 0, 32'h2700, 0, 10);
    send(0, 2'b10, 0, 32'h2704, 0, 11);
    idle(1);
    apply_reset(1);
    stray_force = 2; dly_mode = 2;
    send(0, 2'b10, 0, 32'h2604, 0, 12);
    idle(3);
    drain();

    // randomized traffic
    gnt_mode = 2; dly_mode = -1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0:       base = 32'h2600;
        1:       base = 32'h27FC;
        2:       base = 32'h2800;
        3:       base = 32'h25FC;
        default: base = $urandom & 32'hFFFF_FFFC;
      endcase
      send($urandom_range(0, 1), ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
           $urandom_range(0, 1), base + $urandom_range(0, 7), $urandom, 5'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
